muldiv_iter: RTL and testbench

//   Parametrised iterative multiply/divide unit for the EX stage. Executes MULT, MULTU,
//   DIV and DIVU on WIDTH-bit operands and returns the {hi,lo} pair for the HI/LO registers.

---
 rtl/muldiv_iter.sv | 157 +++++++++++++++
 tb/tb_muldiv_iter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: MULT/MULTU/DIV/DIVU on WIDTH-bit operands,
// fixed WIDTH+2 cycle latency, {hi,lo} result with annul (flush) support.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic [1:0]           op_q;
  logic [WIDTH-1:0]     opnd_q;      // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]     dividend_q;  // raw dividend bits for the divide-by-zero result
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 div_zero_q;
  logic                 ovf_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   result_q;

  // Operand preparation at the accepting edge
  logic             accept;
  logic             sgn_op;
  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;

  assign sgn_op = ~op_i[0];
  assign s1     = sgn_op & opdata1_i[WIDTH-1];
  assign s2     = sgn_op & opdata2_i[WIDTH-1];
  assign mag1   = s1 ? -opdata1_i : opdata1_i;
  assign mag2   = s2 ? -opdata2_i : opdata2_i;
  assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i && !annul_i;

  // One iteration step of either datapath
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   acc_mul;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       rem_diff;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   acc_div;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, opnd_q} & {(WIDTH+1){acc_q[0]}});
  assign acc_mul  = {mul_sum, acc_q[WIDTH-1:1]};
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign rem_ge   = rem_sh >= {1'b0, opnd_q};
  assign rem_new  = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign acc_div  = {rem_new, acc_q[WIDTH-2:0], rem_ge};

  // Sign correction and special cases applied in FIX
  logic [WIDTH-1:0]   quo, rem;
  logic [2*WIDTH-1:0] fix_result;

  assign quo = acc_q[WIDTH-1:0];
  assign rem = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    fix_result = acc_q;
    if (!op_q[1]) begin
      fix_result = neg_res_q ? -acc_q : acc_q;
    end else if (div_zero_q) begin
      fix_result = {dividend_q, {WIDTH{1'b1}}};
    end else if (ovf_q) begin
      fix_result = {{WIDTH{1'b0}}, MIN_VAL};
    end else begin
      fix_result = {(neg_rem_q ? -rem : rem), (neg_res_q ? -quo : quo)};
    end
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    ready_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_CALC;
      end
      S_CALC: begin
        busy_o = 1'b1;
        if (annul_i)                                 state_d = S_IDLE;
        else if (cnt_q == CNT_W'(WIDTH - 1))         state_d = S_FIX;
      end
      S_FIX: begin
        busy_o  = 1'b1;
        state_d = annul_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        ready_o = 1'b1;
        state_d = accept ? S_CALC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      opnd_q     <= '0;
      dividend_q <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        op_q       <= op_i;
        opnd_q     <= op_i[1] ? mag2 : mag1;
        dividend_q <= opdata1_i;
        neg_res_q  <= s1 ^ s2;
        neg_rem_q  <= s1;
        div_zero_q <= op_i[1] && (opdata2_i == '0);
        ovf_q      <= (op_i == OP_DIV) && (opdata1_i == MIN_VAL) && (opdata2_i == '1);
        acc_q      <= {{WIDTH{1'b0}}, (op_i[1] ? mag1 : mag2)};
        cnt_q      <= '0;
      end else if (state_q == S_CALC && !annul_i) begin
        acc_q <= op_q[1] ? acc_div : acc_mul;
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_FIX && !annul_i) result_q <= fix_result;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter (WIDTH=32): latency, results, annul, back-to-back, reset.
module tb_muldiv_iter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [1:0]    op_i;
  logic [W-1:0]  opdata1_i, opdata2_i;
  logic          annul_i;
  logic          busy_o, ready_o;
  logic [2*W-1:0] result_o;

  int vectors = 0;
  int miscompares = 0;
  logic [2*W-1:0] last_exp;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .result_o  (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives a request for one cycle, returns at the negedge of cycle 1.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i   = 1'b1;
    op_i      = op;
    opdata1_i = a;
    opdata2_i = b;
    @(negedge clk);
    start_i   = 1'b0;
    op_i      = 2'($urandom);
    opdata1_i = $urandom;
    opdata2_i = $urandom;
  endtask

  // Waits (bounded) for ready_o, checking latency, busy_o profile and the result.
  task automatic wait_done(input string tag, input logic [63:0] exp);
    int cyc = 1;
    int busy_bad = 0;
    while (!ready_o && cyc < 40) begin
      if (!busy_o) busy_bad++;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'd34);
    check({tag, " busy"}, 64'(busy_bad), 64'd0);
    check({tag, " busy_done"}, 64'(busy_o), 64'd0);
    check({tag, " result"}, result_o, exp);
    last_exp = exp;
  endtask

  initial begin
    int ready_seen;
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00;
    opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
    #1;
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Multiplies
    launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu max", 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    launch(MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult -3*7", 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    launch(MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult min*min", 64'h4000_0000_0000_0000);
    @(negedge clk);

    // Divides
    launch(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div -7/2", 64'hFFFF_FFFF_FFFF_FFFD);
    @(negedge clk);
    launch(DIVU, 32'd7, 32'd2);
    wait_done("divu 7/2", 64'h0000_0001_0000_0003);
    @(negedge clk);
    launch(DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done("div 7/-2", 64'h0000_0001_FFFF_FFFD);
    @(negedge clk);
    launch(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div min/-1", 64'h0000_0000_8000_0000);
    @(negedge clk);
    launch(DIVU, 32'd5, 32'd0);
    wait_done("divu 5/0", 64'h0000_0005_FFFF_FFFF);
    @(negedge clk);
    launch(DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done("div -5/0", 64'hFFFF_FFFB_FFFF_FFFF);
    @(negedge clk);

    // Annul in CALC cycle 10: no ready, result unchanged
    launch(DIVU, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul busy", 64'(busy_o), 64'd0);
    ready_seen = 0;
    repeat (40) begin
      if (ready_o) ready_seen++;
      @(negedge clk);
    end
    check("annul no ready", 64'(ready_seen), 64'd0);
    check("annul result held", result_o, last_exp);

    // start with annul in IDLE is not accepted
    start_i = 1'b1; annul_i = 1'b1; op_i = MULTU;
    opdata1_i = 32'd3; opdata2_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    check("start+annul busy", 64'(busy_o), 64'd0);
    repeat (3) @(negedge clk);
    check("start+annul idle", 64'({busy_o, ready_o}), 64'd0);

    // Back-to-back: second request in the DONE cycle
    launch(DIVU, 32'd7, 32'd2);
    wait_done("b2b first", 64'h0000_0001_0000_0003);
    launch(MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done("b2b second", 64'hFFFF_FFFF_FFFF_FFEB);

    // Annul in DONE: ready still high, start ignored, back to IDLE
    annul_i = 1'b1; start_i = 1'b1; op_i = MULTU;
    check("annul done ready", 64'(ready_o), 64'd1);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    check("annul done idle", 64'({busy_o, ready_o}), 64'd0);
    @(negedge clk);

    // Async reset at CALC cycle 5
    launch(MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst mid busy", 64'(busy_o), 64'd0);
    check("rst mid result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(DIVU, 32'd100, 32'd3);
    wait_done("post rst divu", 64'h0000_0001_0000_0021);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
